rect_burst_sched: RTL and testbench

//  Schedules interpolation bursts for the rectifier. Arbitrates left/right burst requests round-robin,

---
 rtl/rect_burst_sched.sv | 140 ++++++++++++++
 tb/tb_rect_burst_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_burst_sched.sv
// rect_burst_sched: round-robin burst scheduler for the rectifier remap engine.
// It tracks bursts in flight through rect_intp by counting vout pixels against each burst's length.
module rect_burst_sched #(
    parameter int MAX_OUTST = 2,
    parameter int GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_l_req,
    input  logic [8:0] i_l_ydst,
    input  logic [9:0] i_l_xdst,
    input  logic [6:0] i_l_len,
    input  logic       i_l_last,
    output logic       o_l_ack,
    input  logic       i_r_req,
    input  logic [8:0] i_r_ydst,
    input  logic [9:0] i_r_xdst,
    input  logic [6:0] i_r_len,
    input  logic       i_r_last,
    output logic       o_r_ack,
    input  logic       i_lb_rdy_l,
    input  logic       i_lb_rdy_r,
    input  logic       i_obuf_full,
    output logic       o_rm_start,
    output logic       o_rm_lr,
    output logic [8:0] o_rm_ydst,
    output logic [9:0] o_rm_xdst,
    output logic [6:0] o_rm_len,
    output logic       o_rm_last,
    input  logic       i_rm_busy,
    input  logic       i_intp_vout,
    output logic       o_burst_done,
    output logic       o_line_done,
    output logic       o_done_lr,
    output logic [1:0] o_outst,
    output logic       o_busy,
    output logic       o_err
);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [1:0] MAX_O = 2'(MAX_OUTST);
    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_GAP} state_t;
    typedef struct packed {
        logic [6:0] len;
        logic       last;
        logic       lr;
    } trk_t;
    state_t        r_state, w_next;
    logic          r_rr;
    logic          r_run1;
    logic [GW-1:0] r_gap;
    logic          r_rm_lr, r_rm_last;
    logic [8:0]    r_rm_ydst;
    logic [9:0]    r_rm_xdst;
    logic [6:0]    r_rm_len;
    trk_t          r_q [2];
    logic [1:0]    r_outst;
    logic [6:0]    r_pix;
    logic          r_burst_done, r_line_done, r_done_lr, r_err;
    logic          w_room, w_elig_l, w_elig_r, w_grant, w_pick_r;
    logic          w_push, w_vout_ok, w_pop, w_pidx;
    assign w_room    = r_outst < MAX_O;
    assign w_elig_l  = i_l_req & i_lb_rdy_l & ~i_obuf_full & w_room;
    assign w_elig_r  = i_r_req & i_lb_rdy_r & ~i_obuf_full & w_room;
    assign w_grant   = w_elig_l | w_elig_r;
    assign w_pick_r  = w_elig_r & (~w_elig_l | r_rr);
    assign w_push    = (r_state == S_START) && (r_rm_len != 7'd0);
    assign w_vout_ok = i_intp_vout && (r_outst != 2'd0);
    assign w_pop     = w_vout_ok && ({1'b0, r_pix} + 8'd1 == {1'b0, r_q[0].len});
    // A push lands behind the head unless the head leaves in the same cycle.
    assign w_pidx    = (r_outst == 2'd1) && !w_pop;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_grant ? S_START : S_IDLE;
            S_START: w_next = (r_rm_len == 7'd0) ? S_IDLE : S_RUN;
            S_RUN:   w_next = (!r_run1 && !i_rm_busy) ? S_GAP : S_RUN;
            S_GAP:   w_next = (r_gap == GW'(GAP_CYC - 1)) ? S_IDLE : S_GAP;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr         <= 1'b0;
            r_run1       <= 1'b0;
            r_gap        <= '0;
            r_rm_lr      <= 1'b0;
            r_rm_last    <= 1'b0;
            r_rm_ydst    <= '0;
            r_rm_xdst    <= '0;
            r_rm_len     <= '0;
            r_q[0]       <= '0;
            r_q[1]       <= '0;
            r_outst      <= '0;
            r_pix        <= '0;
            r_burst_done <= 1'b0;
            r_line_done  <= 1'b0;
            r_done_lr    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run1  <= r_state == S_START;
            r_gap   <= (r_state == S_GAP) ? r_gap + GW'(1) : '0;
            if (r_state == S_IDLE && w_grant) begin
                r_rm_lr   <= w_pick_r;
                r_rr      <= ~w_pick_r;
                r_rm_ydst <= w_pick_r ? i_r_ydst : i_l_ydst;
                r_rm_xdst <= w_pick_r ? i_r_xdst : i_l_xdst;
                r_rm_len  <= w_pick_r ? i_r_len  : i_l_len;
                r_rm_last <= w_pick_r ? i_r_last : i_l_last;
            end
            r_burst_done <= w_pop;
            r_line_done  <= w_pop & r_q[0].last;
            r_done_lr    <= w_pop ? r_q[0].lr : r_done_lr;
            if (w_vout_ok)
                r_pix <= w_pop ? '0 : r_pix + 7'd1;
            if (w_pop)
                r_q[0] <= r_q[1];
            if (w_push)
                r_q[w_pidx] <= '{len: r_rm_len, last: r_rm_last, lr: r_rm_lr};
            r_outst <= r_outst + {1'b0, w_push} - {1'b0, w_pop};
            if (i_intp_vout && r_outst == 2'd0)
                r_err <= 1'b1;
        end
    end
    assign o_l_ack      = (r_state == S_START) && !r_rm_lr;
    assign o_r_ack      = (r_state == S_START) && r_rm_lr;
    assign o_rm_start   = w_push;
    assign o_rm_lr      = r_rm_lr;
    assign o_rm_ydst    = r_rm_ydst;
    assign o_rm_xdst    = r_rm_xdst;
    assign o_rm_len     = r_rm_len;
    assign o_rm_last    = r_rm_last;
    assign o_burst_done = r_burst_done;
    assign o_line_done  = r_line_done;
    assign o_done_lr    = r_done_lr;
    assign o_outst      = r_outst;
    assign o_busy       = (r_state != S_IDLE) || (r_outst != 2'd0);
    assign o_err        = r_err;
endmodule

// File: tb/tb_rect_burst_sched.sv
// tb_rect_burst_sched: directed bench for rect_burst_sched with a simple remap-engine busy model.
module tb_rect_burst_sched;
    logic       clk, rst;
    logic       l_req, l_last, r_req, r_last;
    logic [8:0] l_ydst, r_ydst;
    logic [9:0] l_xdst, r_xdst;
    logic [6:0] l_len, r_len;
    logic       lb_rdy_l, lb_rdy_r, obuf_full, rm_busy, man_v, auto_v;
    logic       intp_vout;
    logic       o_l_ack, o_r_ack, o_rm_start, o_rm_lr, o_rm_last;
    logic [8:0] o_rm_ydst;
    logic [9:0] o_rm_xdst;
    logic [6:0] o_rm_len;
    logic       o_burst_done, o_line_done, o_done_lr, o_busy, o_err;
    logic [1:0] o_outst;
    int         cyc, fall_cyc, n_chk, n_err;
    bit         ok;

    rect_burst_sched #(.MAX_OUTST(2), .GAP_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .i_l_req(l_req), .i_l_ydst(l_ydst), .i_l_xdst(l_xdst), .i_l_len(l_len), .i_l_last(l_last),
        .o_l_ack(o_l_ack),
        .i_r_req(r_req), .i_r_ydst(r_ydst), .i_r_xdst(r_xdst), .i_r_len(r_len), .i_r_last(r_last),
        .o_r_ack(o_r_ack),
        .i_lb_rdy_l(lb_rdy_l), .i_lb_rdy_r(lb_rdy_r), .i_obuf_full(obuf_full),
        .o_rm_start(o_rm_start), .o_rm_lr(o_rm_lr), .o_rm_ydst(o_rm_ydst), .o_rm_xdst(o_rm_xdst),
        .o_rm_len(o_rm_len), .o_rm_last(o_rm_last),
        .i_rm_busy(rm_busy), .i_intp_vout(intp_vout),
        .o_burst_done(o_burst_done), .o_line_done(o_line_done), .o_done_lr(o_done_lr),
        .o_outst(o_outst), .o_busy(o_busy), .o_err(o_err)
    );

    assign intp_vout = man_v | (auto_v & (o_outst != 2'd0));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever @(posedge clk) cyc++;
    end

    // Remap engine stand-in: busy for rm_len cycles after each rm_start.
    initial begin
        rm_busy  = 0;
        fall_cyc = 0;
        forever begin
            @(negedge clk);
            if (o_rm_start) begin
                rm_busy = 1;
                repeat (int'(o_rm_len)) @(negedge clk);
                rm_busy  = 0;
                fall_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        l_req = 0; r_req = 0; l_last = 0; r_last = 0;
        l_ydst = 0; r_ydst = 0; l_xdst = 0; r_xdst = 0; l_len = 0; r_len = 0;
        lb_rdy_l = 0; lb_rdy_r = 0; obuf_full = 0; man_v = 0; auto_v = 0;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic wait_start(input int bound, output bit found);
        found = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (o_rm_start) begin
                found = 1;
                break;
            end
        end
    endtask

    task automatic pulse_vout(input int n);
        @(negedge clk);
        man_v = 1;
        repeat (n - 1) begin
            @(negedge clk);
            check("no_early_done", o_burst_done, 0);
        end
        @(negedge clk);
        man_v = 0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        do_reset();
        check("rst_outs", {o_l_ack, o_r_ack, o_rm_start, o_rm_lr, o_rm_ydst, o_rm_xdst, o_rm_len,
                           o_rm_last, o_burst_done, o_line_done, o_done_lr, o_outst, o_busy, o_err}, 0);

        // single left burst, 1-cycle latency, completion after 4 pixels
        l_req = 1; l_ydst = 9'd5; l_xdst = 10'd17; l_len = 7'd4; lb_rdy_l = 1;
        @(negedge clk);
        check("t1_start", o_rm_start, 1);
        check("t1_lack", o_l_ack, 1);
        check("t1_rack", o_r_ack, 0);
        check("t1_lr", o_rm_lr, 0);
        check("t1_desc", {o_rm_ydst, o_rm_xdst, o_rm_len}, {9'd5, 10'd17, 7'd4});
        l_req = 0;
        @(negedge clk);
        check("t1_outst1", o_outst, 1);
        check("t1_pulse", {o_rm_start, o_l_ack}, 0);
        repeat (12) @(negedge clk);
        check("t1_busy_outst", o_busy, 1);
        pulse_vout(4);
        check("t1_done", o_burst_done, 1);
        check("t1_done_lr", o_done_lr, 0);
        check("t1_line", o_line_done, 0);
        check("t1_outst0", o_outst, 0);
        @(negedge clk);
        check("t1_done_pulse", o_burst_done, 0);
        check("t1_idle", o_busy, 0);

        // round-robin L,R,L,R with exact idle gap after rm_busy falls
        do_reset();
        auto_v = 1;
        l_req = 1; r_req = 1; l_len = 7'd3; r_len = 7'd3; lb_rdy_l = 1; lb_rdy_r = 1;
        for (int k = 0; k < 4; k++) begin
            wait_start(60, ok);
            check($sformatf("t2_start%0d", k), ok, 1);
            check($sformatf("t2_lr%0d", k), o_rm_lr, k % 2);
            if (k > 0) check($sformatf("t2_gap%0d", k), cyc - fall_cyc, 4);
        end
        l_req = 0; r_req = 0;
        repeat (20) @(negedge clk);
        check("t2_drained", {o_outst, o_busy}, 0);
        check("t2_err", o_err, 0);

        // outstanding limit: third request waits for the first completion
        do_reset();
        l_req = 1; l_len = 7'd2; lb_rdy_l = 1;
        begin
            int starts, acks;
            starts = 0; acks = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                starts += int'(o_rm_start);
                acks += int'(o_l_ack);
            end
            check("t3_starts", starts, 2);
            check("t3_acks", acks, 2);
        end
        check("t3_outst2", o_outst, 2);
        pulse_vout(2);
        check("t3_done", o_burst_done, 1);
        check("t3_outst1", o_outst, 1);
        @(negedge clk);
        check("t3_third_start", o_rm_start, 1);
        l_req = 0;
        @(negedge clk);
        check("t3_outst_back2", o_outst, 2);

        // obuf_full blocks a ready right request until it clears
        do_reset();
        r_req = 1; r_len = 7'd2; lb_rdy_r = 1; obuf_full = 1;
        begin
            int acks;
            acks = 0;
            repeat (10) begin
                @(negedge clk);
                acks += int'(o_r_ack);
            end
            check("t4_full_noack", acks, 0);
        end
        obuf_full = 0;
        @(negedge clk);
        check("t4_full_ack", {o_r_ack, o_rm_start, o_rm_lr}, 3'b111);
        r_req = 0;

        // missing line-buffer readiness blocks in the same way
        do_reset();
        r_req = 1; r_len = 7'd2; lb_rdy_r = 0; lb_rdy_l = 1;
        begin
            int acks;
            acks = 0;
            repeat (10) begin
                @(negedge clk);
                acks += int'(o_r_ack) + int'(o_l_ack);
            end
            check("t4_lb_noack", acks, 0);
        end
        lb_rdy_r = 1;
        @(negedge clk);
        check("t4_lb_ack", {o_r_ack, o_rm_start, o_rm_lr}, 3'b111);
        r_req = 0;

        // zero-length request: ack only, pointer still advances
        do_reset();
        l_req = 1; l_len = 7'd0; lb_rdy_l = 1; lb_rdy_r = 1;
        @(negedge clk);
        check("t5_zero_ack", {o_l_ack, o_rm_start}, 2'b10);
        l_req = 0;
        @(negedge clk);
        check("t5_zero_outst", {o_outst, o_busy}, 0);
        l_req = 1; l_len = 7'd2; r_req = 1; r_len = 7'd2;
        @(negedge clk);
        check("t5_rr_right", {o_rm_start, o_rm_lr, o_r_ack, o_l_ack}, 4'b1110);
        l_req = 0; r_req = 0;

        // last-of-line burst reports line_done with burst_done
        do_reset();
        r_req = 1; r_len = 7'd5; r_last = 1; lb_rdy_r = 1;
        @(negedge clk);
        check("t5_last_start", {o_rm_start, o_rm_last}, 2'b11);
        r_req = 0;
        repeat (3) @(negedge clk);
        pulse_vout(5);
        check("t5_last_done", {o_burst_done, o_line_done, o_done_lr, o_outst}, 5'b11100);
        @(negedge clk);
        check("t5_last_pulse", {o_burst_done, o_line_done}, 0);

        // reset mid-burst with two in flight, then a stray pixel flags err
        do_reset();
        l_req = 1; l_len = 7'd4; lb_rdy_l = 1;
        wait_start(40, ok);
        check("t6_start1", ok, 1);
        wait_start(40, ok);
        check("t6_start2", ok, 1);
        l_req = 0;
        @(negedge clk);
        check("t6_outst2", {o_outst, o_busy}, 3'b101);
        rst = 1;
        @(negedge clk);
        check("t6_rst_outs", {o_l_ack, o_r_ack, o_rm_start, o_rm_lr, o_rm_ydst, o_rm_xdst, o_rm_len,
                              o_rm_last, o_burst_done, o_line_done, o_done_lr, o_outst, o_busy, o_err}, 0);
        rst = 0;
        @(negedge clk);
        man_v = 1;
        @(negedge clk);
        man_v = 0;
        check("t6_err", o_err, 1);
        repeat (3) @(negedge clk);
        check("t6_err_sticky", {o_err, o_burst_done, o_outst}, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
